player_motion_ctrl: RTL and testbench
=====================================

// Module: player_motion_ctrl
// PURPOSE
//  Parametrised player movement engine for the VGA game datapath: takes four
//  synchronous direction buttons, advances a sprite position once per move
//  tick with per-axis acceleration, clamps it to the playfield, and flags
//  scan pixels that fall inside the sprite box. Sits between button input
//  logic and the pixel renderer. Replaces the fixed-step player block.
// PARAMETERS
//  COORD_W   10   width of all coordinates
//  X_MAX     639  last visible column
//  Y_MAX     479  last visible row
//  SPRITE_W  16   sprite width, pixels (1..X_MAX+1)
//  SPRITE_H  16   sprite height, pixels (1..Y_MAX+1)
//  X_INIT    312  reset x position (must be <= X_MAX-SPRITE_W+1)
//  Y_INIT    232  reset y position (must be <= Y_MAX-SPRITE_H+1)
//  TICK_DIV  416667  clk cycles per move tick (>=2)
//  MAX_SPEED 4    top speed, pixels per tick (>=1)
// PORTS
//  clk         in   1        system clock, rising edge
//  reset       in   1        asynchronous, active-low reset
//  ctrl_up     in   1        button, synchronous to clk (decreasing y)
//  ctrl_down   in   1        button (increasing y)
//  ctrl_left   in   1        button (decreasing x)
//  ctrl_right  in   1        button (increasing x)
//  x           in   COORD_W  current scan column
//  y           in   COORD_W  current scan row
//  player_x    out  COORD_W  sprite top-left column
//  player_y    out  COORD_W  sprite top-left row
//  player_hit  out  1        scan pixel (x,y) lies inside sprite, 1-cycle latency
//  moving      out  1        either axis speed nonzero
//  at_edge     out  4        {top,bottom,left,right} clamp flags
// BEHAVIOUR
//  Reset (reset=0, async): player_x=X_INIT, player_y=Y_INIT, all speeds 0,
//   tick counter 0, player_hit=0, moving=0, at_edge from the init position.
//  Tick: counter runs 0..TICK_DIV-1 then wraps; tick=1 in the cycle count==TICK_DIV-1.
//   Positions, speeds and edge flags update only on the clk edge where tick=1.
//  Per axis, net dir: up&down or left&right together, or neither -> 0 (cancel).
//   Up/left alone -> -1; down/right alone -> +1.
//  Speed per axis, on a tick: dir 0 -> speed 0; dir differs from previous tick's
//   dir (incl. reversal) -> speed 1; same nonzero dir -> min(speed+1, MAX_SPEED).
//  Position on a tick: pos +/- new speed, computed in COORD_W+1 bits signed;
//   result <0 -> 0; result > LIM -> LIM, LIM = X_MAX-SPRITE_W+1 (x) or
//   Y_MAX-SPRITE_H+1 (y). Axes are independent; diagonal moves both in the same tick.
//  When a clamp occurs, that axis speed is forced to 0, so the next tick in the
//   same dir restarts at 1.
//  at_edge bit set when the axis sits at its limit (0 or LIM), updated with position.
//  moving = (speed_x != 0) | (speed_y != 0), registered.
//  player_hit: registered each clk from x>=player_x && x<player_x+SPRITE_W &&
//   y>=player_y && y<player_y+SPRITE_H using the current (pre-update) position;
//   comparisons are COORD_W+1 bits wide, no wrap.
//  Button changes between ticks have no effect; only the level at the tick counts.
//  Reset asserted mid-move: everything returns to reset values immediately;
//   the first tick after release falls TICK_DIV cycles later.
// TESTING (bench uses TICK_DIV=4, defaults otherwise)
//  Reset release -> player_x=312, player_y=232, moving=0, first tick 4 cycles after release.
//  ctrl_right held 6 ticks -> x 313,315,318,322,326,330 (speed 1,2,3,4,4,4); release -> speed 0, x holds at 330.
//  ctrl_left+ctrl_right held 3 ticks -> x unchanged, moving=0; up+right together -> x and y step on the same tick.
//  ctrl_up held from y=232 for 70 ticks -> y clamps at 0, at_edge[3]=1, speed 0; release then press -> next step 1.
//  Right reversed to left after reaching speed 4 -> next tick x decreases by 1.
//  Scan x=312..327,y=232 -> player_hit=1 one cycle later; x=311 or 328 -> 0. Reset pulse mid-move -> x=312 at once.

Source files
------------

// File: rtl/player_motion_ctrl.sv
// Player movement engine: per-axis accelerating motion on a divided move tick,
// playfield clamping, edge flags and a registered sprite hit test for the scan pixel.
module player_motion_ctrl #(
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned Y_MAX     = 479,
  parameter int unsigned SPRITE_W  = 16,
  parameter int unsigned SPRITE_H  = 16,
  parameter int unsigned X_INIT    = 312,
  parameter int unsigned Y_INIT    = 232,
  parameter int unsigned TICK_DIV  = 416667,
  parameter int unsigned MAX_SPEED = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ctrl_up,
  input  logic               ctrl_down,
  input  logic               ctrl_left,
  input  logic               ctrl_right,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] player_x,
  output logic [COORD_W-1:0] player_y,
  output logic               player_hit,
  output logic               moving,
  output logic [3:0]         at_edge
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam int unsigned SPD_W = $clog2(MAX_SPEED + 1);
  localparam int unsigned EXT_W = COORD_W + 2;
  localparam int unsigned HIT_W = COORD_W + 1;
  localparam int unsigned LIM_X = X_MAX - SPRITE_W + 1;
  localparam int unsigned LIM_Y = Y_MAX - SPRITE_H + 1;
  localparam logic [3:0]  EDGE_INIT = {Y_INIT == 0, Y_INIT == LIM_Y, X_INIT == 0, X_INIT == LIM_X};

  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic [1:0]         dir_x, dir_y, prev_x, prev_y;
  logic [SPD_W-1:0]   spd_x, spd_y, nspd_x, nspd_y;
  logic [COORD_W-1:0] npos_x, npos_y;
  logic               clamp_x, clamp_y;
  logic               hit_c;

  // Direction code: 2'b00 none/cancelled, 2'b01 increasing, 2'b11 decreasing.
  function automatic logic [1:0] net_dir(input logic neg, input logic pos);
    return (neg ^ pos) ? {neg, 1'b1} : 2'b00;
  endfunction

  function automatic logic [SPD_W-1:0] next_speed(input logic [1:0] dir, input logic [1:0] prev,
                                                  input logic [SPD_W-1:0] spd);
    if (dir == 2'b00) return '0;
    if (dir != prev) return SPD_W'(1);
    if (spd >= SPD_W'(MAX_SPEED)) return SPD_W'(MAX_SPEED);
    return spd + SPD_W'(1);
  endfunction

  // Returns {clamped, new_pos}; the signed sum is wide enough to never wrap.
  function automatic logic [COORD_W:0] step_pos(input logic [COORD_W-1:0] pos, input logic [1:0] dir,
                                                input logic [SPD_W-1:0] spd, input logic [COORD_W-1:0] lim);
    logic signed [EXT_W-1:0] delta;
    logic signed [EXT_W-1:0] sum;
    delta = $signed(EXT_W'(spd));
    sum   = dir[1] ? $signed(EXT_W'(pos)) - delta : $signed(EXT_W'(pos)) + delta;
    if (sum[EXT_W-1]) return {1'b1, COORD_W'(0)};
    if (sum > $signed(EXT_W'(lim))) return {1'b1, lim};
    return {1'b0, COORD_W'(sum)};
  endfunction

  always_comb begin
    tick   = (cnt == CNT_W'(TICK_DIV - 1));
    dir_x  = net_dir(ctrl_left, ctrl_right);
    dir_y  = net_dir(ctrl_up, ctrl_down);
    nspd_x = next_speed(dir_x, prev_x, spd_x);
    nspd_y = next_speed(dir_y, prev_y, spd_y);
    {clamp_x, npos_x} = step_pos(player_x, dir_x, nspd_x, COORD_W'(LIM_X));
    {clamp_y, npos_y} = step_pos(player_y, dir_y, nspd_y, COORD_W'(LIM_Y));
    hit_c = (HIT_W'(x) >= HIT_W'(player_x)) && (HIT_W'(x) < HIT_W'(player_x) + HIT_W'(SPRITE_W)) &&
            (HIT_W'(y) >= HIT_W'(player_y)) && (HIT_W'(y) < HIT_W'(player_y) + HIT_W'(SPRITE_H));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + CNT_W'(1);
  end

  // Motion state advances only on the tick; a clamp kills that axis' speed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      player_x <= COORD_W'(X_INIT);
      player_y <= COORD_W'(Y_INIT);
      spd_x    <= '0;
      spd_y    <= '0;
      prev_x   <= 2'b00;
      prev_y   <= 2'b00;
      moving   <= 1'b0;
      at_edge  <= EDGE_INIT;
    end else if (tick) begin
      player_x <= npos_x;
      player_y <= npos_y;
      spd_x    <= clamp_x ? '0 : nspd_x;
      spd_y    <= clamp_y ? '0 : nspd_y;
      prev_x   <= dir_x;
      prev_y   <= dir_y;
      moving   <= (!clamp_x && (nspd_x != '0)) || (!clamp_y && (nspd_y != '0));
      at_edge  <= {npos_y == '0, npos_y == COORD_W'(LIM_Y), npos_x == '0, npos_x == COORD_W'(LIM_X)};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) player_hit <= 1'b0;
    else player_hit <= hit_c;
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl with a 4-cycle move tick.
module tb_player_motion_ctrl;
  localparam int TD   = 4;
  localparam int LIMX = 624;
  localparam int LIMY = 464;

  logic       clk = 1'b0;
  logic       reset;
  logic       ctrl_up, ctrl_down, ctrl_left, ctrl_right;
  logic [9:0] x, y;
  logic [9:0] player_x, player_y;
  logic       player_hit, moving;
  logic [3:0] at_edge;

  player_motion_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset),
    .ctrl_up(ctrl_up), .ctrl_down(ctrl_down), .ctrl_left(ctrl_left), .ctrl_right(ctrl_right),
    .x(x), .y(y),
    .player_x(player_x), .player_y(player_y), .player_hit(player_hit),
    .moving(moving), .at_edge(at_edge)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] px;
    logic [9:0] py;
    logic       mv;
    logic [3:0] edg;
  } exp_t;

  exp_t q[$];
  logic hq[$];
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;
  int   mx, my, sx, sy, pdx, pdy;

  always @(posedge clk or negedge reset) begin
    if (!reset) edges <= 0;
    else edges <= edges + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    mx = 312; my = 232; sx = 0; sy = 0; pdx = 0; pdy = 0;
    q.delete();
    hq.delete();
  endtask

  task automatic axis(input int d, input int lim, inout int pos, inout int spd, inout int pd);
    if (d == 0) spd = 0;
    else if (d != pd) spd = 1;
    else spd = (spd + 1 > 4) ? 4 : spd + 1;
    pos = pos + d * spd;
    if (pos < 0) begin pos = 0; spd = 0; end
    else if (pos > lim) begin pos = lim; spd = 0; end
    pd = d;
  endtask

  // Drive buttons for the coming tick and push the expected post-tick state.
  task automatic drive(input logic u, input logic d, input logic l, input logic r);
    int   dx, dy;
    exp_t e;
    ctrl_up = u; ctrl_down = d; ctrl_left = l; ctrl_right = r;
    dx = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
    dy = (d && !u) ? 1 : ((u && !d) ? -1 : 0);
    axis(dx, LIMX, mx, sx, pdx);
    axis(dy, LIMY, my, sy, pdy);
    e.px  = 10'(mx);
    e.py  = 10'(my);
    e.mv  = (sx != 0) || (sy != 0);
    e.edg = {my == 0, my == LIMY, mx == 0, mx == LIMX};
    q.push_back(e);
  endtask

  task automatic next_tick();
    for (int i = 0; i < TD; i++) begin
      @(posedge clk);
      #1;
      if (edges % TD == 0) break;
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = q.pop_front();
      if ({player_x, player_y, moving, at_edge} !== e) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d mv=%b edge=%b, want x=%0d y=%0d mv=%b edge=%b",
                 name, player_x, player_y, moving, at_edge, e.px, e.py, e.mv, e.edg);
      end
    end
  endtask

  task automatic step(input logic u, input logic d, input logic l, input logic r, input string name);
    drive(u, d, l, r);
    next_tick();
    pop_check(name);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    ctrl_up = 0; ctrl_down = 0; ctrl_left = 0; ctrl_right = 0;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({player_x, player_y, moving, player_hit, at_edge} !== {10'd312, 10'd232, 1'b0, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_values: got x=%0d y=%0d mv=%b hit=%b edge=%b, want 312 232 0 0 0000",
               player_x, player_y, moving, player_hit, at_edge);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    drive(0, 0, 0, 1);
    for (int i = 1; i < TD; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (player_x !== 10'd312) begin
        errors++;
        $display("FAIL first_tick_early: edge %0d got x=%0d want 312", i, player_x);
      end
    end
    @(posedge clk);
    #1;
    pop_check("first_tick");
  endtask

  task automatic test_right();
    int xs[6] = '{313, 315, 318, 322, 326, 330};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1, "right_hold");
      checks++;
      if (player_x !== 10'(xs[i])) begin
        errors++;
        $display("FAIL right_seq: tick %0d got x=%0d want %0d", i, player_x, xs[i]);
      end
    end
    step(0, 0, 0, 0, "right_release");
  endtask

  task automatic test_cancel();
    apply_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, "lr_cancel");
    step(1, 0, 0, 1, "diag_up_right");
    step(1, 1, 0, 0, "ud_cancel");
  endtask

  task automatic test_reverse();
    apply_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, "rev_accel");
    step(0, 0, 1, 0, "rev_left");
    checks++;
    if (player_x !== 10'd321) begin
      errors++;
      $display("FAIL reverse_step: got x=%0d want 321", player_x);
    end
  endtask

  task automatic test_clamp();
    apply_reset();
    for (int i = 0; i < 70; i++) step(1, 0, 0, 0, "up_clamp");
    checks++;
    if ({player_y, at_edge[3], moving} !== {10'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL top_clamp: got y=%0d top=%b mv=%b want 0 1 0", player_y, at_edge[3], moving);
    end
    step(0, 0, 0, 0, "clamp_release");
    step(0, 1, 0, 0, "clamp_restart");
    checks++;
    if (player_y !== 10'd1) begin
      errors++;
      $display("FAIL restart_step: got y=%0d want 1", player_y);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, "left_walk");
  endtask

  task automatic test_between();
    apply_reset();
    step(0, 0, 0, 0, "idle");
    @(negedge clk);
    ctrl_right = 1'b1;
    @(negedge clk);
    ctrl_right = 1'b0;
    step(0, 0, 0, 0, "pulse_ignored");
  endtask

  task automatic probe(input logic [9:0] px, input logic [9:0] py, input string name);
    logic got;
    @(negedge clk);
    x = px;
    y = py;
    hq.push_back((px >= mx) && (px < mx + 16) && (py >= my) && (py < my + 16));
    @(posedge clk);
    #1;
    got = hq.pop_front();
    checks++;
    if (player_hit !== got) begin
      errors++;
      $display("FAIL %s: x=%0d y=%0d got hit=%b want %b", name, px, py, player_hit, got);
    end
  endtask

  task automatic test_hit();
    int xs[5] = '{311, 312, 319, 327, 328};
    int ys[4] = '{231, 232, 247, 248};
    apply_reset();
    foreach (xs[i]) probe(10'(xs[i]), 10'd232, "hit_x");
    foreach (ys[i]) probe(10'd320, 10'(ys[i]), "hit_y");
    step(0, 0, 0, 1, "hit_move");
    probe(10'd312, 10'd240, "hit_moved_left");
    probe(10'd328, 10'd240, "hit_moved_right");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, "pre_reset_move");
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({player_x, player_y, moving, at_edge} !== {10'd312, 10'd232, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL mid_reset: got x=%0d y=%0d mv=%b edge=%b want 312 232 0 0000",
               player_x, player_y, moving, at_edge);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 1, "post_reset_tick");
  endtask

  initial begin
    reset = 1'b0;
    ctrl_up = 0; ctrl_down = 0; ctrl_left = 0; ctrl_right = 0;
    x = '0;
    y = '0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_right();
    test_cancel();
    test_reverse();
    test_clamp();
    test_between();
    test_hit();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
